idma_irq_ctrl: RTL and testbench
================================

# idma_irq_ctrl

Parametrised completion-interrupt controller for iDMA in the CVA6 system. It generalises the fixed two-bit read/write-done pending register to `NumChannels` channels, each with a read-done and a write-done source. Each source has its own enable bit, and the pending register uses write-1-to-clear (W1C) semantics. Interrupt coalescing combines an event-count threshold with a timeout. The block sits beside the iDMA frontends on the 64-bit register bus and drives the wired interrupt lines into the PLIC.

## Interface
Parameters:
- `NumChannels`, 2, number of DMA channels (1..16); source count N = 2*NumChannels.
- `CntWidth`, 8, width of the coalescing event counter and of the threshold register.
- `TimeoutWidth`, 16, width of the coalescing timer and of the timeout register.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; **synchronous, active-high**.
- `r_done_i`  in  NumChannels  one-cycle pulse per channel on last R beat.
- `w_done_i`  in  NumChannels  one-cycle pulse per channel on last W beat.
- `reg_valid_i`  in  1  register request valid.
- `reg_write_i`  in  1  1 = write, 0 = read.
- `reg_addr_i`  in  6  byte address; bits [5:3] select the register.
- `reg_wdata_i`  in  64  write data.
- `reg_wstrb_i`  in  8  byte strobes; a register updates only if all 8 strobes are set.
- `reg_rdata_o`  out  64  read data.
- `reg_ready_o`  out  1  request accepted; tied to 1.
- `reg_error_o`  out  1  request targets an unmapped address.
- `irq_o`  out  2*NumChannels  interrupt lines. Bit 2c is the read-done line for channel c; bit 2c+1 is the write-done line for channel c.

## Operation
Register map (64-bit, reset values in brackets):
- 0x00 PENDING, W1C [0]. Bit 2c is set by `r_done_i[c]`; bit 2c+1 is set by `w_done_i[c]`.
- 0x08 ENABLE, RW [0]. Per-source mask, N bits.
- 0x10 COAL_THRESH, RW [1]. Bits [CntWidth-1:0]. A value of 0 behaves as 1.
- 0x18 COAL_TIMEOUT, RW [0]. Bits [TimeoutWidth-1:0]. A value of 0 disables the timeout.
- 0x20 EVT_COUNT, RO. Current coalescing count, zero-extended.
- 0x28 STATUS, RO. Bit 0 = armed, bit 1 = timer running.
- 0x30 and 0x38 are unmapped. Access returns `reg_error_o`=1 and rdata 0, with no side effect.

Register bus behaviour:
- Unused upper bits read 0 and ignore writes.
- Writes to RO registers are ignored, with error=0.

Event capture:
- Each source pulse sets its pending bit, whether or not the source is enabled.
- An event and a W1C to the same bit in the same cycle leave the bit set (event wins).

Event counter:
- Counts the enabled pulses in each cycle. The increment is the popcount of (`{w_done_i,r_done_i}` interleaved) & ENABLE, range 0..N.
- The counter saturates at 2^CntWidth-1.

Coalescing state machine (IDLE, COUNTING, ARMED):
- IDLE → COUNTING when count_next > 0 and count_next < threshold.
- IDLE or COUNTING → ARMED when count_next >= threshold.
- COUNTING → ARMED when the timer reaches COAL_TIMEOUT != 0.
- Entering ARMED clears the count and the timer. Events that arrive while ARMED still set pending bits but are not counted.
- ARMED → IDLE when (PENDING & ENABLE) == 0 after the current cycle's update. This covers clearing by W1C and clearing by disabling sources.
- The timer is cleared on entering COUNTING and increments every cycle while in COUNTING.

Interrupt output:
- `irq_o` = PENDING & ENABLE when in ARMED, otherwise 0. It is a registered output.
- Writing ENABLE while ARMED masks or unmasks lines on the next cycle.
- Reducing COAL_THRESH to a value ≤ the current count arms the block on the next cycle.

## Timing
- Reset: PENDING=0, ENABLE=0, COAL_THRESH=1, COAL_TIMEOUT=0, count=0, timer=0, state IDLE, `irq_o`=0, `reg_error_o`=0, `reg_rdata_o`=0.
- Reset asserted mid-operation clears all state at the next edge. Pulses in the reset cycle are dropped.
- An event at cycle t sets PENDING at t+1. With threshold 1 and the source enabled, `irq_o` rises at t+1.
- Timeout T with count ≥ 1 below threshold: the timer reaches T T cycles after entering COUNTING, and `irq_o` rises one cycle later.
- A W1C at cycle t updates PENDING at t+1. `irq_o` drops at t+1 if no enabled pending bits remain.
- Register access has zero wait states. Read data is combinational from the current register state, so a read in the same cycle as a write returns the old value.

## Test plan
- Reset, then ENABLE=0x3 (NumChannels=2), pulse `r_done_i[0]` → PENDING=0x1 and `irq_o`=0b0001 one cycle later. Write 0x1 to PENDING → `irq_o`=0 on the next cycle and STATUS.armed=0.
- THRESH=3, ENABLE=0xF, pulse `w_done_i=0b11` in one cycle → EVT_COUNT=2, no IRQ. One more `r_done_i[1]` pulse → `irq_o`=0b1110 and EVT_COUNT=0.
- THRESH=10, TIMEOUT=5, one enabled event → STATUS.bit1=1. `irq_o` asserts exactly 6 cycles after the event cycle.
- ENABLE=0, events on all 4 sources → PENDING=0xF, `irq_o`=0, EVT_COUNT=0. Then ENABLE=0x4 with THRESH=1 → no IRQ, because count is 0 and the state is IDLE.
- While ARMED, W1C of bit 0 in the same cycle as an `r_done_i[0]` pulse → PENDING bit 0 stays 1 and `irq_o` stays asserted.
- Read 0x30 → `reg_error_o`=1, rdata 0. Write with wstrb=0x0F to ENABLE → ENABLE unchanged. Assert `rst_i` while ARMED → all outputs return to reset values next cycle.

Source files
------------

// File: rtl/idma_irq_ctrl.sv
// Completion-interrupt controller for iDMA: per-channel read/write-done pending bits with W1C,
// per-source enables, and count/timeout interrupt coalescing on a 64-bit register bus.
module idma_irq_ctrl #(
    parameter int unsigned NumChannels  = 2,
    parameter int unsigned CntWidth     = 8,
    parameter int unsigned TimeoutWidth = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NumChannels-1:0]     r_done_i,
    input  logic [NumChannels-1:0]     w_done_i,
    input  logic                       reg_valid_i,
    input  logic                       reg_write_i,
    input  logic [5:0]                 reg_addr_i,
    input  logic [63:0]                reg_wdata_i,
    input  logic [7:0]                 reg_wstrb_i,
    output logic [63:0]                reg_rdata_o,
    output logic                       reg_ready_o,
    output logic                       reg_error_o,
    output logic [2*NumChannels-1:0]   irq_o
);

    localparam int unsigned N        = 2 * NumChannels;
    localparam int unsigned IncWidth = $clog2(N + 1);

    localparam logic [2:0] SEL_PENDING = 3'd0;
    localparam logic [2:0] SEL_ENABLE  = 3'd1;
    localparam logic [2:0] SEL_THRESH  = 3'd2;
    localparam logic [2:0] SEL_TIMEOUT = 3'd3;
    localparam logic [2:0] SEL_COUNT   = 3'd4;
    localparam logic [2:0] SEL_STATUS  = 3'd5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNTING = 2'd1,
        ARMED    = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [N-1:0]            pending_q, pending_d;
    logic [N-1:0]            enable_q, enable_d;
    logic [CntWidth-1:0]     thresh_q, thresh_d;
    logic [TimeoutWidth-1:0] timeout_q, timeout_d;
    logic [CntWidth-1:0]     count_q, count_d;
    logic [TimeoutWidth-1:0] timer_q, timer_d;
    logic [N-1:0]            irq_q, irq_d;

    logic [N-1:0]            events;
    logic [N-1:0]            w1c_mask;
    logic [IncWidth-1:0]     inc;
    logic [CntWidth:0]       count_sum;
    logic [CntWidth-1:0]     count_sat;
    logic [CntWidth-1:0]     thresh_eff;
    logic [TimeoutWidth-1:0] timer_inc;
    logic                    wr_en;
    logic [2:0]              sel;
    logic                    unused_ok;

    assign sel         = reg_addr_i[5:3];
    assign wr_en       = reg_valid_i & reg_write_i & (&reg_wstrb_i);
    assign reg_ready_o = 1'b1;
    assign irq_o       = irq_q;
    assign unused_ok   = ^{reg_wdata_i, reg_addr_i[2:0]};

    // Interleave sources so bit 2c is read-done and bit 2c+1 is write-done of channel c.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        events = '0;
        for (int c = 0; c < int'(NumChannels); c++) begin
            events[2*c]   = r_done_i[c];
            events[2*c+1] = w_done_i[c];
        end
    end

    // Register-file next state; an event overrides a same-cycle W1C on its bit.
    always_comb begin
        w1c_mask  = (wr_en && sel == SEL_PENDING) ? reg_wdata_i[N-1:0] : '0;
        pending_d = (pending_q & ~w1c_mask) | events;
        enable_d  = (wr_en && sel == SEL_ENABLE)  ? reg_wdata_i[N-1:0] : enable_q;
        thresh_d  = (wr_en && sel == SEL_THRESH)  ? reg_wdata_i[CntWidth-1:0] : thresh_q;
        timeout_d = (wr_en && sel == SEL_TIMEOUT) ? reg_wdata_i[TimeoutWidth-1:0] : timeout_q;
    end

    always_comb begin
        inc = '0;
        for (int i = 0; i < int'(N); i++) begin
            inc = inc + {{(IncWidth-1){1'b0}}, events[i] & enable_q[i]};
        end
        count_sum  = {1'b0, count_q} + (CntWidth+1)'(inc);
        count_sat  = count_sum[CntWidth] ? '1 : count_sum[CntWidth-1:0];
        thresh_eff = (thresh_q == '0) ? CntWidth'(1) : thresh_q;
        timer_inc  = (timer_q == '1) ? timer_q : timer_q + TimeoutWidth'(1);
    end

    // Coalescing FSM: ARMED leaves only once no enabled source is pending.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        timer_d = timer_q;
        unique case (state_q)
            IDLE: begin
                count_d = count_sat;
                if (count_sat >= thresh_eff) begin
                    state_d = ARMED;
                    count_d = '0;
                    timer_d = '0;
                end else if (count_sat != '0) begin
                    state_d = COUNTING;
                    timer_d = '0;
                end
            end
            COUNTING: begin
                count_d = count_sat;
                timer_d = timer_inc;
                if (count_sat >= thresh_eff ||
                    (timeout_q != '0 && timer_inc >= timeout_q)) begin
                    state_d = ARMED;
                    count_d = '0;
                    timer_d = '0;
                end
            end
            ARMED: begin
                count_d = '0;
                timer_d = '0;
                if ((pending_d & enable_d) == '0) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
                timer_d = '0;
            end
        endcase
        irq_d = (state_d == ARMED) ? (pending_d & enable_d) : '0;
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            state_q   <= IDLE;
            pending_q <= '0;
            enable_q  <= '0;
            thresh_q  <= CntWidth'(1);
            timeout_q <= '0;
            count_q   <= '0;
            timer_q   <= '0;
            irq_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            enable_q  <= enable_d;
            thresh_q  <= thresh_d;
            timeout_q <= timeout_d;
            count_q   <= count_d;
            timer_q   <= timer_d;
            irq_q     <= irq_d;
        end
    end

    // Read path is combinational from current state, so a same-cycle write is not yet visible.
    always_comb begin
        reg_rdata_o = '0;
        reg_error_o = 1'b0;
        if (reg_valid_i) begin
            unique case (sel)
                SEL_PENDING: reg_rdata_o[N-1:0]            = reg_write_i ? '0 : pending_q;
                SEL_ENABLE:  reg_rdata_o[N-1:0]            = reg_write_i ? '0 : enable_q;
                SEL_THRESH:  reg_rdata_o[CntWidth-1:0]     = reg_write_i ? '0 : thresh_q;
                SEL_TIMEOUT: reg_rdata_o[TimeoutWidth-1:0] = reg_write_i ? '0 : timeout_q;
                SEL_COUNT:   reg_rdata_o[CntWidth-1:0]     = reg_write_i ? '0 : count_q;
                SEL_STATUS:  reg_rdata_o[1:0]              = reg_write_i ? 2'b00 :
                                                             {state_q == COUNTING, state_q == ARMED};
                default:     reg_error_o                   = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_idma_irq_ctrl.sv
// Directed bench for idma_irq_ctrl (NumChannels=2): capture, W1C, coalescing by count and
// timeout, masking, bus errors, strobes and synchronous reset.
module tb_idma_irq_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  r_done_i;
    logic [1:0]  w_done_i;
    logic        reg_valid_i;
    logic        reg_write_i;
    logic [5:0]  reg_addr_i;
    logic [63:0] reg_wdata_i;
    logic [7:0]  reg_wstrb_i;
    logic [63:0] reg_rdata_o;
    logic        reg_ready_o;
    logic        reg_error_o;
    logic [3:0]  irq_o;

    int total = 0;
    int bad   = 0;

    logic [63:0] rd;
    logic        er;

    idma_irq_ctrl #(.NumChannels(2), .CntWidth(8), .TimeoutWidth(16)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .r_done_i    (r_done_i),
        .w_done_i    (w_done_i),
        .reg_valid_i (reg_valid_i),
        .reg_write_i (reg_write_i),
        .reg_addr_i  (reg_addr_i),
        .reg_wdata_i (reg_wdata_i),
        .reg_wstrb_i (reg_wstrb_i),
        .reg_rdata_o (reg_rdata_o),
        .reg_ready_o (reg_ready_o),
        .reg_error_o (reg_error_o),
        .irq_o       (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic reg_wr(input logic [5:0] a, input logic [63:0] d, input logic [7:0] s);
        reg_valid_i = 1'b1;
        reg_write_i = 1'b1;
        reg_addr_i  = a;
        reg_wdata_i = d;
        reg_wstrb_i = s;
        tick();
        reg_valid_i = 1'b0;
        reg_write_i = 1'b0;
        reg_wstrb_i = 8'h00;
        reg_wdata_i = '0;
    endtask

    task automatic reg_rd(input logic [5:0] a, output logic [63:0] d, output logic e);
        reg_valid_i = 1'b1;
        reg_write_i = 1'b0;
        reg_addr_i  = a;
        #1;
        d = reg_rdata_o;
        e = reg_error_o;
        reg_valid_i = 1'b0;
        #1;
    endtask

    task automatic pulse(input logic [1:0] r, input logic [1:0] w);
        r_done_i = r;
        w_done_i = w;
        tick();
        r_done_i = 2'b00;
        w_done_i = 2'b00;
    endtask

    initial begin
        rst_i       = 1'b1;
        r_done_i    = 2'b00;
        w_done_i    = 2'b00;
        reg_valid_i = 1'b0;
        reg_write_i = 1'b0;
        reg_addr_i  = '0;
        reg_wdata_i = '0;
        reg_wstrb_i = '0;
        tick();
        tick();

        // Reset state
        check("rst_irq", 64'(irq_o), 64'h0);
        check("rst_error", 64'(reg_error_o), 64'h0);
        check("rst_rdata", reg_rdata_o, 64'h0);
        check("ready", 64'(reg_ready_o), 64'h1);
        rst_i = 1'b0;
        reg_rd(6'h10, rd, er);
        check("rst_thresh", rd, 64'h1);

        // Single event with threshold 1, then W1C
        reg_wr(6'h08, 64'h3, 8'hFF);
        pulse(2'b01, 2'b00);
        check("t1_irq", 64'(irq_o), 64'h1);
        reg_rd(6'h00, rd, er);
        check("t1_pending", rd, 64'h1);
        reg_wr(6'h00, 64'h1, 8'hFF);
        check("t1_irq_clr", 64'(irq_o), 64'h0);
        reg_rd(6'h28, rd, er);
        check("t1_status", rd, 64'h0);

        // Count threshold 3
        reg_wr(6'h10, 64'd3, 8'hFF);
        reg_wr(6'h08, 64'hF, 8'hFF);
        pulse(2'b00, 2'b11);
        reg_rd(6'h20, rd, er);
        check("t2_count2", rd, 64'd2);
        check("t2_noirq", 64'(irq_o), 64'h0);
        pulse(2'b10, 2'b00);
        check("t2_irq", 64'(irq_o), 64'hE);
        reg_rd(6'h20, rd, er);
        check("t2_count0", rd, 64'd0);
        reg_wr(6'h00, 64'hF, 8'hFF);
        check("t2_irq_clr", 64'(irq_o), 64'h0);

        // Timeout 5 with threshold 10: irq 6 cycles after the event cycle
        reg_wr(6'h10, 64'd10, 8'hFF);
        reg_wr(6'h18, 64'd5, 8'hFF);
        pulse(2'b01, 2'b00);
        reg_rd(6'h28, rd, er);
        check("t3_running", rd, 64'h2);
        for (int i = 0; i < 3; i++) tick();
        check("t3_irq_t4", 64'(irq_o), 64'h0);
        tick();
        check("t3_irq_t5", 64'(irq_o), 64'h0);
        tick();
        check("t3_irq_t6", 64'(irq_o), 64'h1);
        reg_rd(6'h28, rd, er);
        check("t3_armed", rd, 64'h1);
        reg_wr(6'h00, 64'h1, 8'hFF);
        reg_wr(6'h18, 64'd0, 8'hFF);
        check("t3_irq_clr", 64'(irq_o), 64'h0);

        // Disabled sources still latch pending but never count or interrupt
        reg_wr(6'h08, 64'h0, 8'hFF);
        pulse(2'b11, 2'b11);
        reg_rd(6'h00, rd, er);
        check("t4_pending", rd, 64'hF);
        check("t4_irq", 64'(irq_o), 64'h0);
        reg_rd(6'h20, rd, er);
        check("t4_count", rd, 64'd0);
        reg_wr(6'h10, 64'd1, 8'hFF);
        reg_wr(6'h08, 64'h4, 8'hFF);
        tick();
        check("t4_irq_en", 64'(irq_o), 64'h0);
        reg_rd(6'h28, rd, er);
        check("t4_status", rd, 64'h0);
        reg_wr(6'h00, 64'hF, 8'hFF);

        // Event wins over a same-cycle W1C while ARMED
        reg_wr(6'h08, 64'h1, 8'hFF);
        pulse(2'b01, 2'b00);
        check("t5_irq", 64'(irq_o), 64'h1);
        reg_valid_i = 1'b1;
        reg_write_i = 1'b1;
        reg_addr_i  = 6'h00;
        reg_wdata_i = 64'h1;
        reg_wstrb_i = 8'hFF;
        r_done_i    = 2'b01;
        tick();
        reg_valid_i = 1'b0;
        reg_write_i = 1'b0;
        reg_wstrb_i = 8'h00;
        r_done_i    = 2'b00;
        reg_rd(6'h00, rd, er);
        check("t5_pending", rd, 64'h1);
        check("t5_irq_hold", 64'(irq_o), 64'h1);

        // Unmapped access, partial strobes, RO write
        reg_rd(6'h30, rd, er);
        check("t6_err", 64'(er), 64'h1);
        check("t6_err_rdata", rd, 64'h0);
        reg_rd(6'h28, rd, er);
        check("t6_mapped_err", 64'(er), 64'h0);
        reg_wr(6'h08, 64'h0, 8'h0F);
        reg_rd(6'h08, rd, er);
        check("t6_wstrb", rd, 64'h1);
        reg_wr(6'h20, 64'h55, 8'hFF);
        reg_rd(6'h20, rd, er);
        check("t6_ro_write", rd, 64'h0);
        check("t6_irq_still", 64'(irq_o), 64'h1);

        // Synchronous reset while ARMED
        rst_i    = 1'b1;
        r_done_i = 2'b11;
        tick();
        check("t7_irq", 64'(irq_o), 64'h0);
        rst_i    = 1'b0;
        r_done_i = 2'b00;
        reg_rd(6'h00, rd, er);
        check("t7_pending", rd, 64'h0);
        reg_rd(6'h08, rd, er);
        check("t7_enable", rd, 64'h0);
        reg_rd(6'h10, rd, er);
        check("t7_thresh", rd, 64'h1);
        reg_rd(6'h28, rd, er);
        check("t7_status", rd, 64'h0);
        check("t7_rdata_idle", reg_rdata_o, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
